// File: rtl/capture_if.sv
// Handshake and sample-RAM signals between the capture sequencer and its surroundings.
// The master side is the capture controller. The slave side is the trigger, command and RAM logic.
interface capture_if #(
  parameter int ADDR_W = 9
);
  logic              cap_start;
  logic              cap_abort;
  logic              smpl_en;
  logic [ADDR_W-1:0] trig_pos;
  logic              triggered;
  logic              trig_en;
  logic              armed;
  logic              set_capture_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trace_end;
  logic              capture_done;
  logic              busy;

  modport master (
    input  cap_start, cap_abort, smpl_en, trig_pos, triggered,
    output trig_en, armed, set_capture_done, we, waddr, trace_end, capture_done, busy
  );

  modport slave (
    output cap_start, cap_abort, smpl_en, trig_pos, triggered,
    input  trig_en, armed, set_capture_done, we, waddr, trace_end, capture_done, busy
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer for the circular sample RAM: pre-trigger fill, trigger hand-off,
// post-trigger count and completion reporting.
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic     clk,
  input  logic     rst_n,
  capture_if.master bus
);

  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

  localparam logic [ADDR_W:0]   FILL_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   FILL_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;
  logic [ADDR_W-1:0] trace_end_reg, trace_end_next;
  logic [ADDR_W:0]   fill_cnt_reg, fill_cnt_next;
  logic              armed_reg, armed_next;
  logic              done_reg, done_next;
  logic              scd_reg, scd_next;
  logic              busy_reg, busy_next;
  logic              trig_en_reg, trig_en_next;
  logic              capturing;
  logic              post_complete;
  logic              we_int;

  assign capturing     = (state_reg == PRE) || (state_reg == POST);
  assign post_complete = (state_reg == POST) && (post_cnt_reg == bus.trig_pos);
  // The strobe that lands on the completion cycle would be one past the trace, so it is dropped.
  assign we_int        = bus.smpl_en && capturing && !post_complete;

  always_comb begin
    state_next     = state_reg;
    waddr_next     = waddr_reg;
    post_cnt_next  = post_cnt_reg;
    trace_end_next = trace_end_reg;
    fill_cnt_next  = fill_cnt_reg;
    armed_next     = armed_reg;
    done_next      = done_reg;
    scd_next       = 1'b0;

    if (we_int) begin
      waddr_next = waddr_reg + ADDR_ONE;
    end

    case (state_reg)
      IDLE, DONE: begin
        if (bus.cap_start) begin
          state_next    = PRE;
          fill_cnt_next = '0;
          post_cnt_next = '0;
          done_next     = 1'b0;
        end
      end
      PRE: begin
        if (bus.cap_abort) begin
          state_next = IDLE;
          armed_next = 1'b0;
          scd_next   = 1'b1;
        end else begin
          if (we_int && (fill_cnt_reg != FILL_MAX)) begin
            fill_cnt_next = fill_cnt_reg + FILL_ONE;
          end
          if (bus.triggered) begin
            state_next = POST;
          end else begin
            // Sum tops out at 2*2**ADDR_W-1, so ADDR_W+1 bits cannot overflow.
            armed_next = (({1'b0, bus.trig_pos} + fill_cnt_next) >= FILL_MAX);
          end
        end
      end
      POST: begin
        if (bus.cap_abort) begin
          state_next = IDLE;
          armed_next = 1'b0;
          scd_next   = 1'b1;
        end else if (post_complete) begin
          state_next     = DONE;
          trace_end_next = waddr_reg - ADDR_ONE;
          armed_next     = 1'b0;
          done_next      = 1'b1;
          scd_next       = 1'b1;
        end else if (we_int) begin
          post_cnt_next = post_cnt_reg + ADDR_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next    = (state_next == PRE) || (state_next == POST);
    trig_en_next = (state_next == PRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      waddr_reg     <= '0;
      post_cnt_reg  <= '0;
      trace_end_reg <= '0;
      fill_cnt_reg  <= '0;
      armed_reg     <= 1'b0;
      done_reg      <= 1'b0;
      scd_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      trig_en_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      waddr_reg     <= waddr_next;
      post_cnt_reg  <= post_cnt_next;
      trace_end_reg <= trace_end_next;
      fill_cnt_reg  <= fill_cnt_next;
      armed_reg     <= armed_next;
      done_reg      <= done_next;
      scd_reg       <= scd_next;
      busy_reg      <= busy_next;
      trig_en_reg   <= trig_en_next;
    end
  end

  assign bus.we               = we_int;
  assign bus.waddr            = waddr_reg;
  assign bus.trace_end        = trace_end_reg;
  assign bus.armed            = armed_reg;
  assign bus.capture_done     = done_reg;
  assign bus.set_capture_done = scd_reg;
  assign bus.busy             = busy_reg;
  assign bus.trig_en          = trig_en_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: expected write addresses are queued at stimulus
// time and popped by a monitor whenever the controller writes the sample RAM.
module tb_capture_ctrl;
  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  logic rst_n;

  capture_if #(.ADDR_W(ADDR_W)) bus ();

  capture_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int                n_vec  = 0;
  int                n_miss = 0;
  int                nwr;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] exp_trace;
  logic              fire;
  logic              trig_sr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Behavioural trigger SR flop: set on request while armed and enabled, cleared by set_capture_done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     trig_sr <= 1'b0;
    else if (bus.set_capture_done)  trig_sr <= 1'b0;
    else if (fire && bus.armed && bus.trig_en) trig_sr <= 1'b1;
  end
  assign bus.triggered = trig_sr;

  always @(negedge clk) begin
    if (rst_n && bus.we) begin
      if (exp_q.size() == 0) check("unexpected_we", 32'(bus.waddr), 32'hFFFF_FFFF);
      else                   check("waddr", 32'(bus.waddr), 32'(exp_q.pop_front()));
    end
  end

  // One clock cycle of stimulus; returns at the following falling edge.
  task automatic cyc(input logic s, input logic st, input logic ab, input bit wr);
    @(posedge clk);
    #1;
    fire          = 1'b0;
    bus.smpl_en   = s;
    bus.cap_start = st;
    bus.cap_abort = ab;
    if (wr) begin
      exp_q.push_back(exp_addr);
      exp_addr = exp_addr + 1'b1;
      nwr++;
    end
    @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_trig_en"},   32'(bus.trig_en), 32'd0);
    check({pre, "_armed"},     32'(bus.armed), 32'd0);
    check({pre, "_scd"},       32'(bus.set_capture_done), 32'd0);
    check({pre, "_we"},        32'(bus.we), 32'd0);
    check({pre, "_waddr"},     32'(bus.waddr), 32'd0);
    check({pre, "_trace_end"}, 32'(bus.trace_end), 32'd0);
    check({pre, "_done"},      32'(bus.capture_done), 32'd0);
    check({pre, "_busy"},      32'(bus.busy), 32'd0);
  endtask

  task automatic check_completion(input string pre, input logic [ADDR_W-1:0] te);
    check({pre, "_scd"},       32'(bus.set_capture_done), 32'd1);
    check({pre, "_done"},      32'(bus.capture_done), 32'd1);
    check({pre, "_armed"},     32'(bus.armed), 32'd0);
    check({pre, "_busy"},      32'(bus.busy), 32'd0);
    check({pre, "_trig_en"},   32'(bus.trig_en), 32'd0);
    check({pre, "_trace_end"}, 32'(bus.trace_end), 32'(te));
  endtask

  initial begin
    rst_n         = 1'b0;
    fire          = 1'b0;
    nwr           = 0;
    exp_addr      = '0;
    exp_trace     = '0;
    bus.smpl_en   = 1'b0;
    bus.cap_start = 1'b0;
    bus.cap_abort = 1'b0;
    bus.trig_pos  = 9'd100;
    #12;
    check_zero("rst");
    #10 rst_n = 1'b1;

    repeat (3) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("idle_we", 32'(bus.we), 32'd0);
    end

    // Capture 1: trig_pos=100, full-rate strobes, trigger 20 writes after arming.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    nwr = 0;
    for (int i = 0; i < 432; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      check("c1_armed", 32'(bus.armed), 32'((nwr - 1) >= 412));
      check("c1_trig_en", 32'(bus.trig_en), 32'd1);
    end
    fire = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("c1_trig_en_trig", 32'(bus.trig_en), 32'd1);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      check("c1_post_trig_en", 32'(bus.trig_en), 32'd0);
      check("c1_post_busy", 32'(bus.busy), 32'd1);
      check("c1_post_scd", 32'(bus.set_capture_done), 32'd0);
    end
    exp_trace = exp_addr - 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("c1_we_suppressed", 32'(bus.we), 32'd0);
    check("c1_scd_early", 32'(bus.set_capture_done), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_completion("c1", exp_trace);
    $display("capture 1: trig_pos=100 trace_end=%0d capture_done=%0b", bus.trace_end, bus.capture_done);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("c1_scd_once", 32'(bus.set_capture_done), 32'd0);
    check("c1_done_held", 32'(bus.capture_done), 32'd1);
    check_drained("c1_drained");

    // Capture 2: restart from DONE, 1/4-rate strobes, abort together with trigger.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("c2_done_before", 32'(bus.capture_done), 32'd1);
    nwr = 0;
    for (int k = 0; k < 4000 && nwr < 488; k++) begin
      bit s;
      s = ((k % 4) == 3);
      cyc(s, 1'b0, 1'b0, s);
      if (k == 0) begin
        check("c2_done_cleared", 32'(bus.capture_done), 32'd0);
        check("c2_busy", 32'(bus.busy), 32'd1);
      end
      check("c2_armed", 32'(bus.armed), 32'((nwr - int'(s)) >= 412));
    end
    check("c2_writes", 32'(nwr), 32'd488);
    fire = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("c2_triggered", 32'(bus.triggered), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c2_abort_busy", 32'(bus.busy), 32'd0);
    check("c2_abort_armed", 32'(bus.armed), 32'd0);
    check("c2_abort_scd", 32'(bus.set_capture_done), 32'd1);
    check("c2_abort_done", 32'(bus.capture_done), 32'd0);
    check("c2_abort_trace", 32'(bus.trace_end), 32'(exp_trace));
    check("c2_abort_trig_en", 32'(bus.trig_en), 32'd0);
    $display("capture 2: aborted trace_end=%0d waddr=%0d", bus.trace_end, bus.waddr);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("c2_scd_once", 32'(bus.set_capture_done), 32'd0);
    check("c2_waddr_510", 32'(bus.waddr), 32'(exp_addr));
    check_drained("c2_drained");

    // Capture 3: trig_pos=0 from waddr=510, wraps the buffer, completes with no POST writes.
    bus.trig_pos = 9'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    nwr = 0;
    for (int i = 0; i < 512; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      check("c3_armed", 32'(bus.armed), 32'((nwr - 1) >= 512));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c3_armed_512", 32'(bus.armed), 32'd1);
    fire = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c3_trig_en", 32'(bus.trig_en), 32'd1);
    exp_trace = exp_addr - 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("c3_we_suppressed", 32'(bus.we), 32'd0);
    check("c3_post_busy", 32'(bus.busy), 32'd1);
    check("c3_post_trig_en", 32'(bus.trig_en), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_completion("c3", exp_trace);
    $display("capture 3: trig_pos=0 trace_end=%0d capture_done=%0b", bus.trace_end, bus.capture_done);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c3_scd_once", 32'(bus.set_capture_done), 32'd0);
    check_drained("c3_drained");

    // Capture 4: trig_pos=511 from DONE, arms after one write, aborted in POST.
    bus.trig_pos = 9'd511;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("c4_done_before", 32'(bus.capture_done), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c4_armed_start", 32'(bus.armed), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c4_fill_restart", 32'(bus.armed), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("c4_armed_pre", 32'(bus.armed), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c4_armed_one", 32'(bus.armed), 32'd1);
    fire = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("c4_post_trig_en", 32'(bus.trig_en), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c4_abort_busy", 32'(bus.busy), 32'd0);
    check("c4_abort_scd", 32'(bus.set_capture_done), 32'd1);
    check("c4_abort_done", 32'(bus.capture_done), 32'd0);
    check("c4_abort_armed", 32'(bus.armed), 32'd0);
    check("c4_abort_trace", 32'(bus.trace_end), 32'(exp_trace));
    $display("capture 4: aborted in POST trace_end=%0d", bus.trace_end);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("c4_scd_once", 32'(bus.set_capture_done), 32'd0);
    check_drained("c4_drained");

    // Capture 5: asynchronous reset in the middle of POST with writes active.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    fire = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("c5_post_we", 32'(bus.we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("c5_rst");
    exp_q.delete();
    exp_addr = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    $display("capture 5: reset during POST, outputs cleared");
    repeat (3) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("c5_we_after", 32'(bus.we), 32'd0);
      check("c5_busy_after", 32'(bus.busy), 32'd0);
      check("c5_waddr_after", 32'(bus.waddr), 32'd0);
    end
    check_drained("c5_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Capture sequencer on the consumer side of the trigger handshake in the DSO.
- Drives trig_en, armed and set_capture_done into the trigger logic, and consumes its registered triggered flag.
- Manages the 512-entry circular sample RAM: write enable, write address, pre-trigger fill count and post-trigger count.
- Reports capture completion and the trace end address to the command/readout logic.

Parameters:
ADDR_W, 9, sample RAM address width; the RAM holds 2**ADDR_W entries.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cap_start  input  1  one-cycle pulse that begins a new capture; honoured in IDLE and DONE only
cap_abort  input  1  one-cycle pulse that stops the capture and returns to IDLE
smpl_en  input  1  decimated sample strobe; one RAM write per strobe while capturing
trig_pos  input  ADDR_W  number of post-trigger samples; held stable while busy
triggered  input  1  registered trigger flag from the trigger logic
trig_en  output  1  trigger logic enable
armed  output  1  pre-trigger fill satisfied
set_capture_done  output  1  one-cycle pulse that clears the trigger SR flop
we  output  1  sample RAM write enable
waddr  output  ADDR_W  sample RAM write address
trace_end  output  ADDR_W  address of the last sample written in the completed capture
capture_done  output  1  sticky completion flag
busy  output  1  high in PRE and POST

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n is asynchronous and active-low.
  - During reset, all state registers and all outputs are 0, and the FSM is in IDLE.
- States: IDLE, PRE, POST, DONE. The state register, waddr, fill_cnt (ADDR_W+1 bits, saturating at 2**ADDR_W), post_cnt (ADDR_W bits), armed, trace_end, capture_done and set_capture_done are all registered.
- RAM write path:
  - we = smpl_en & (state==PRE | state==POST). This is the only combinational output.
  - On every write, waddr increments modulo 2**ADDR_W, so 511 wraps to 0.
- IDLE or DONE, on cap_start:
  - Next state PRE.
  - fill_cnt and post_cnt cleared; capture_done cleared.
  - waddr is not reset; the buffer continues from the current position.
- PRE:
  - trig_en = 1.
  - Each write increments fill_cnt, saturating.
  - armed <= (fill_cnt_next + trig_pos >= 2**ADDR_W), computed at ADDR_W+1 bits with no overflow. armed therefore rises on the cycle after the qualifying write.
  - If triggered==1 while in PRE: next state POST, trig_en drops the next cycle, and armed holds.
  - The trigger logic cannot assert triggered unless armed; the controller does not re-check this.
- POST:
  - trig_en = 0.
  - Each write increments post_cnt.
  - Completion condition: post_cnt==trig_pos, evaluated on the registered value.
  - When the condition holds, in the same cycle the controller latches trace_end <= waddr-1 (mod 2**ADDR_W) and goes to DONE. The following cycle has set_capture_done=1 (exactly one cycle), capture_done=1 and armed=0.
  - With trig_pos=0, completion happens on the first POST cycle, and the sample written in that cycle is not counted.
  - If a write and completion coincide, the write is suppressed (we forced to 0).
- DONE:
  - capture_done held at 1; we=0; trig_en=0.
  - Waits for cap_start.
- cap_abort in PRE or POST:
  - Next state IDLE; armed=0.
  - set_capture_done pulses for one cycle to clear any pending trigger.
  - capture_done stays 0 and trace_end is unchanged.
  - cap_abort in IDLE or DONE is ignored.
- Simultaneous events:
  - cap_abort has priority over cap_start and over triggered.
  - cap_start outside IDLE/DONE is ignored.
- busy = (state==PRE | state==POST), registered with the state.
- Latency: triggered high → trig_en low after 1 cycle. Final post-trigger write → set_capture_done after 2 cycles.

Test Plan:
- Reset: assert rst_n=0 mid-POST with writes active → all outputs 0 immediately (asynchronous), state IDLE; after release, we stays 0 until cap_start.
- Arming: trig_pos=100, start capture, smpl_en every cycle → armed rises the cycle after the 412th write and stays high; trig_en high throughout PRE.
- Full capture: trig_pos=100, triggered asserted 20 cycles after armed → exactly 100 POST writes, set_capture_done is a single one-cycle pulse 2 cycles after the last write, capture_done=1, trace_end = last written address.
- Wrap and edge values:
  - trig_pos=0, starting from waddr=510 → armed after 512 writes; trigger gives completion with no POST writes; waddr wraps 511→0 correctly.
  - trig_pos=511 → armed after the first write.
- Abort: cap_abort in the same cycle as triggered during PRE → IDLE, set_capture_done pulses once, capture_done=0, trace_end unchanged.
- Restart and decimation: cap_start from DONE → capture_done clears next cycle and the fill count restarts from 0; with smpl_en at 1/4 rate, counts advance only on strobes.
